// File: rtl/uart_rto_x.sv
// Receive-timeout timer: counts idle bit periods after receive activity and flags
// a timeout after (CCntVal+1)*(RTOVal+1)*pOvrSmp oversample enables.
module uart_rto_x #(
  parameter int unsigned pOvrSmp = 16,
  parameter int unsigned pCCntW  = 4,
  parameter int unsigned pRTOW   = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              CE_OvrSmp,
  input  logic [1:0]        Mode,
  input  logic              WE_RHR,
  input  logic              RE_RHR,
  input  logic              FIFO_Empty,
  input  logic              RxBusy,
  input  logic [pCCntW-1:0] CCntVal,
  input  logic [pRTOW-1:0]  RTOVal,
  output logic              RcvTimeout,
  output logic              RTO_Pls,
  output logic              Armed
);

  localparam int unsigned    BDW      = $clog2(pOvrSmp);
  localparam logic [BDW-1:0] BDIV_PEN = BDW'(pOvrSmp - 2);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ONESHOT = 2'd1,
    MODE_FIFO    = 2'd2,
    MODE_IDLE    = 2'd3
  } mode_e;

  logic [1:0]        r_mode;
  logic              r_armed, r_flag, r_pls;
  logic [BDW-1:0]    r_bdiv;
  logic [pCCntW-1:0] r_ccnt, r_cshd;
  logic [pRTOW-1:0]  r_rcnt, r_rshd;
  logic              r_blast, r_clast, r_rlast;

  logic              w_armed, w_flag, w_pls;
  logic [BDW-1:0]    w_bdiv;
  logic [pCCntW-1:0] w_ccnt, w_cshd, w_ccnt_inc;
  logic [pRTOW-1:0]  w_rcnt, w_rshd, w_rcnt_inc;
  logic              w_blast, w_clast, w_rlast;
  logic              w_restart, w_clrcnt, w_count, w_expire;

  // Terminal-count flags are registered one step ahead, so expiry is a plain AND.
  assign w_expire   = r_armed & CE_OvrSmp & r_blast & r_clast & r_rlast;
  assign w_ccnt_inc = r_ccnt + pCCntW'(1);
  assign w_rcnt_inc = r_rcnt + pRTOW'(1);

  always_comb begin
    w_armed   = r_armed;
    w_flag    = r_flag;
    w_pls     = 1'b0;
    w_bdiv    = r_bdiv;
    w_ccnt    = r_ccnt;
    w_rcnt    = r_rcnt;
    w_cshd    = r_cshd;
    w_rshd    = r_rshd;
    w_blast   = r_blast;
    w_clast   = r_clast;
    w_rlast   = r_rlast;
    w_restart = 1'b0;
    w_clrcnt  = 1'b0;
    w_count   = 1'b0;

    if (Mode != r_mode) begin
      w_armed  = 1'b0;
      w_flag   = 1'b0;
      w_clrcnt = 1'b1;
    end else begin
      case (mode_e'(Mode))
        MODE_ONESHOT: begin
          if (RE_RHR) begin
            w_armed  = 1'b0;
            w_flag   = 1'b0;
            w_clrcnt = 1'b1;
          end else if (WE_RHR) begin
            w_armed   = 1'b1;
            w_restart = 1'b1;
          end else if (r_armed && CE_OvrSmp) begin
            if (w_expire) begin
              w_flag  = 1'b1;
              w_pls   = 1'b1;
              w_armed = 1'b0;
            end else begin
              w_count = 1'b1;
            end
          end
        end
        MODE_FIFO: begin
          if (FIFO_Empty) begin
            w_armed  = 1'b0;
            w_flag   = 1'b0;
            w_clrcnt = 1'b1;
          end else if (RE_RHR || WE_RHR) begin
            w_armed   = 1'b1;
            w_restart = 1'b1;
            if (RE_RHR) w_flag = 1'b0;
          end else if (!r_armed && !r_flag) begin
            // A set flag marks "expired, waiting for FIFO traffic" and blocks re-arming.
            w_armed   = 1'b1;
            w_restart = 1'b1;
          end else if (r_armed && CE_OvrSmp) begin
            if (w_expire) begin
              w_flag  = 1'b1;
              w_pls   = 1'b1;
              w_armed = 1'b0;
            end else begin
              w_count = 1'b1;
            end
          end
        end
        MODE_IDLE: begin
          if (RE_RHR) w_flag = 1'b0;
          if (WE_RHR) begin
            w_armed   = 1'b1;
            w_flag    = 1'b0;
            w_restart = 1'b1;
          end else if (r_armed && RxBusy) begin
            w_clrcnt = 1'b1;
          end else if (r_armed && CE_OvrSmp) begin
            if (w_expire) begin
              w_armed = 1'b0;
              if (!RE_RHR) begin
                w_flag = 1'b1;
                w_pls  = 1'b1;
              end
            end else begin
              w_count = 1'b1;
            end
          end
        end
        default: begin
          w_armed  = 1'b0;
          w_flag   = 1'b0;
          w_clrcnt = 1'b1;
        end
      endcase
    end

    if (w_restart) begin
      w_bdiv  = '0;
      w_ccnt  = '0;
      w_rcnt  = '0;
      w_cshd  = CCntVal;
      w_rshd  = RTOVal;
      w_blast = 1'b0;
      w_clast = (CCntVal == '0);
      w_rlast = (RTOVal == '0);
    end else if (w_clrcnt) begin
      w_bdiv  = '0;
      w_ccnt  = '0;
      w_rcnt  = '0;
      w_blast = 1'b0;
      w_clast = (r_cshd == '0);
      w_rlast = (r_rshd == '0);
    end else if (w_count) begin
      w_bdiv  = r_bdiv + BDW'(1);
      w_blast = (r_bdiv == BDIV_PEN);
      if (r_blast) begin
        if (r_clast) begin
          w_ccnt  = '0;
          w_clast = (r_cshd == '0);
          w_rcnt  = w_rcnt_inc;
          w_rlast = (w_rcnt_inc == r_rshd);
        end else begin
          w_ccnt  = w_ccnt_inc;
          w_clast = (w_ccnt_inc == r_cshd);
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_mode  <= '0;
      r_armed <= 1'b0;
      r_flag  <= 1'b0;
      r_pls   <= 1'b0;
      r_bdiv  <= '0;
      r_ccnt  <= '0;
      r_rcnt  <= '0;
      r_cshd  <= '0;
      r_rshd  <= '0;
      r_blast <= 1'b0;
      r_clast <= 1'b0;
      r_rlast <= 1'b0;
    end else begin
      r_mode  <= Mode;
      r_armed <= w_armed;
      r_flag  <= w_flag;
      r_pls   <= w_pls;
      r_bdiv  <= w_bdiv;
      r_ccnt  <= w_ccnt;
      r_rcnt  <= w_rcnt;
      r_cshd  <= w_cshd;
      r_rshd  <= w_rshd;
      r_blast <= w_blast;
      r_clast <= w_clast;
      r_rlast <= w_rlast;
    end
  end

  assign RcvTimeout = r_flag;
  assign RTO_Pls    = r_pls;
  assign Armed      = r_armed;

endmodule

// File: tb/tb_uart_rto_x.sv
// Bench for uart_rto_x: directed scenarios plus random traffic, checked every cycle
// against a single-counter reference model through an expectation queue.
module tb_uart_rto_x;

  localparam int OVR = 16;

  logic       Clk = 1'b0;
  logic       Rst_n, CE_OvrSmp, WE_RHR, RE_RHR, FIFO_Empty, RxBusy;
  logic [1:0] Mode;
  logic [3:0] CCntVal, RTOVal;
  logic       RcvTimeout, RTO_Pls, Armed;

  always #5 Clk = ~Clk;

  uart_rto_x #(.pOvrSmp(OVR), .pCCntW(4), .pRTOW(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .CE_OvrSmp(CE_OvrSmp), .Mode(Mode),
    .WE_RHR(WE_RHR), .RE_RHR(RE_RHR), .FIFO_Empty(FIFO_Empty), .RxBusy(RxBusy),
    .CCntVal(CCntVal), .RTOVal(RTOVal),
    .RcvTimeout(RcvTimeout), .RTO_Pls(RTO_Pls), .Armed(Armed)
  );

  logic [2:0]  exp_q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference: one count of CE pulses since restart against the full timeout length.
  bit         m_armed, m_flag, m_pls;
  int         m_cnt, m_len, m_npls;
  logic [1:0] m_mprev;

  initial begin : model
    m_npls = 0;
    forever begin
      @(posedge Clk);
      m_pls = 1'b0;
      if (!Rst_n) begin
        m_armed = 0; m_flag = 0; m_cnt = 0; m_len = 0; m_mprev = 2'd0;
      end else begin
        if (Mode != m_mprev) begin
          m_armed = 0; m_flag = 0;
        end else begin
          case (Mode)
            2'd1: begin
              if (RE_RHR) begin
                m_armed = 0; m_flag = 0;
              end else if (WE_RHR) begin
                m_armed = 1; m_cnt = 0; m_len = (int'(CCntVal) + 1) * (int'(RTOVal) + 1) * OVR;
              end else if (m_armed && CE_OvrSmp) begin
                m_cnt++;
                if (m_cnt == m_len) begin m_flag = 1; m_pls = 1; m_armed = 0; end
              end
            end
            2'd2: begin
              if (FIFO_Empty) begin
                m_armed = 0; m_flag = 0;
              end else if (RE_RHR || WE_RHR || (!m_armed && !m_flag)) begin
                m_armed = 1; m_cnt = 0; m_len = (int'(CCntVal) + 1) * (int'(RTOVal) + 1) * OVR;
                if (RE_RHR) m_flag = 0;
              end else if (m_armed && CE_OvrSmp) begin
                m_cnt++;
                if (m_cnt == m_len) begin m_flag = 1; m_pls = 1; m_armed = 0; end
              end
            end
            2'd3: begin
              if (RE_RHR) m_flag = 0;
              if (WE_RHR) begin
                m_armed = 1; m_flag = 0; m_cnt = 0;
                m_len = (int'(CCntVal) + 1) * (int'(RTOVal) + 1) * OVR;
              end else if (m_armed && RxBusy) begin
                m_cnt = 0;
              end else if (m_armed && CE_OvrSmp) begin
                m_cnt++;
                if (m_cnt == m_len) begin
                  m_armed = 0;
                  if (!RE_RHR) begin m_flag = 1; m_pls = 1; end
                end
              end
            end
            default: begin
              m_armed = 0; m_flag = 0;
            end
          endcase
        end
        m_mprev = Mode;
      end
      if (m_pls) m_npls++;
      exp_q.push_back({m_flag, m_pls, m_armed});
    end
  end

  initial begin : monitor
    logic [2:0] e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({RcvTimeout, RTO_Pls, Armed} !== e) begin
          miscompares++;
          $display("FAIL outputs @%0t: got {RcvTimeout,RTO_Pls,Armed}=%b required %b",
                   $time, {RcvTimeout, RTO_Pls, Armed}, e);
        end
      end
    end
  end

  int unsigned ce_per = 1;
  int unsigned ce_rnd = 0;
  int unsigned cyc_n  = 0;

  task automatic drive(input bit we, input bit re);
    @(negedge Clk);
    cyc_n++;
    WE_RHR = we;
    RE_RHR = re;
    if (ce_rnd != 0) CE_OvrSmp = ($urandom_range(ce_rnd - 1, 0) == 0);
    else             CE_OvrSmp = ((cyc_n % ce_per) == 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  initial begin : stim
    Rst_n = 1'b0; CE_OvrSmp = 1'b0; WE_RHR = 1'b0; RE_RHR = 1'b0;
    FIFO_Empty = 1'b1; RxBusy = 1'b0; Mode = 2'd0; CCntVal = 4'd0; RTOVal = 4'd0;
    idle(3);
    Rst_n = 1'b1;
    idle(2);

    // one-shot: 640-cycle expiry, read clear, WE at CE 639, RE at CE 640
    Mode = 2'd1; CCntVal = 4'd9; RTOVal = 4'd3;
    idle(2);
    drive(1'b1, 1'b0); idle(650);
    drive(1'b0, 1'b1); idle(3);
    drive(1'b1, 1'b0); idle(638);
    drive(1'b1, 1'b0); idle(639);
    drive(1'b0, 1'b1); idle(5);

    // FIFO retrigger
    Mode = 2'd2; FIFO_Empty = 1'b1;
    idle(3);
    FIFO_Empty = 1'b0; drive(1'b1, 1'b0);
    idle(99); drive(1'b1, 1'b0);
    idle(700);
    FIFO_Empty = 1'b1; idle(3);
    FIFO_Empty = 1'b0; idle(50);
    drive(1'b0, 1'b1); idle(700);

    // idle-line with a busy receiver mid-count
    Mode = 2'd3;
    idle(2);
    drive(1'b1, 1'b0); idle(499);
    RxBusy = 1'b1; idle(300);
    RxBusy = 1'b0; idle(700);
    drive(1'b0, 1'b1); idle(3);
    drive(1'b1, 1'b0); idle(100);
    drive(1'b0, 1'b1); idle(5);

    // minimum length, sparse CE
    Mode = 2'd1; CCntVal = 4'd0; RTOVal = 4'd0; ce_per = 4;
    idle(2);
    drive(1'b1, 1'b0); idle(80);
    // maximum length
    ce_per = 1; CCntVal = 4'd15; RTOVal = 4'd15;
    drive(1'b1, 1'b0); idle(4100);
    // mid-count config change ignored
    CCntVal = 4'd9; RTOVal = 4'd3;
    drive(1'b1, 1'b0); idle(100);
    CCntVal = 4'd0; RTOVal = 4'd0; idle(700);

    // reset mid-count
    CCntVal = 4'd9; RTOVal = 4'd3;
    drive(1'b1, 1'b0); idle(200);
    Rst_n = 1'b0; idle(1);
    Rst_n = 1'b1; idle(700);

    // mode change with flag set
    CCntVal = 4'd0; RTOVal = 4'd0;
    drive(1'b1, 1'b0); idle(20);
    Mode = 2'd0; idle(1);
    Mode = 2'd1; idle(5);

    // random traffic
    for (int s = 0; s < 12; s++) begin
      Mode    = 2'($urandom_range(3, 0));
      CCntVal = 4'($urandom_range(3, 0));
      RTOVal  = 4'($urandom_range(3, 0));
      ce_rnd  = ($urandom_range(1, 0) == 0) ? 0 : 3;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(199, 0) == 0) FIFO_Empty = ~FIFO_Empty;
        if ($urandom_range(39, 0) == 0)  RxBusy = ~RxBusy;
        if ($urandom_range(499, 0) == 0) CCntVal = 4'($urandom_range(3, 0));
        if ($urandom_range(999, 0) == 0) Mode = 2'($urandom_range(3, 0));
        Rst_n = ($urandom_range(2999, 0) != 0);
        drive($urandom_range(299, 0) == 0, $urandom_range(399, 0) == 0);
      end
    end
    Rst_n = 1'b1; ce_rnd = 0;
    idle(5);
    @(posedge Clk);
    #2;

    vectors++;
    if (m_npls < 8) begin
      miscompares++;
      $display("FAIL expiry_coverage: got %0d expiries required at least 8", m_npls);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rto_x.md
# uart_rto_x

Parametrised receive-timeout timer for the UART receive path: counts idle time, in bit periods, after receive activity and raises a sticky timeout flag plus a one-cycle strobe when the programmed number of character times elapses. It sits between the receiver/receive FIFO and the UART status/interrupt logic. It adds selectable modes over the original fixed-width one-shot timer:
- one-shot arm
- FIFO-level retrigger (16550-style)
- idle-line detect

## Interface
- pOvrSmp, 16: oversample CE pulses per bit period (power of 2, 4..64)
- pCCntW, 4: width of CCntVal
- pRTOW, 4: width of RTOVal
- Clk  in  1  single system clock, all logic on rising edge
- Rst_n  in  1  reset; synchronous and active-low
- CE_OvrSmp  in  1  oversample clock enable, pOvrSmp pulses per bit
- Mode  in  2  0 = off, 1 = one-shot, 2 = FIFO retrigger, 3 = idle-line
- WE_RHR  in  1  character written into RHR/FIFO
- RE_RHR  in  1  host read of RHR
- FIFO_Empty  in  1  receive FIFO empty (used in mode 2)
- RxBusy  in  1  receiver mid-frame, start bit detected (used in mode 3)
- CCntVal  in  pCCntW  bit periods per character, minus 1
- RTOVal  in  pRTOW  character periods per timeout, minus 1
- RcvTimeout  out  1  sticky timeout flag
- RTO_Pls  out  1  one-Clk strobe at expiry
- Armed  out  1  timer running

## Operation
- **Timeout length:** T = (CCntVal+1)·(RTOVal+1)·pOvrSmp CE_OvrSmp pulses after a restart.
- **Restart:**
  - Clears the bit divider (log2(pOvrSmp) bits), the character counter and the RTO counter.
  - Latches CCntVal and RTOVal into shadow registers; a change to CCntVal/RTOVal mid-count has no effect until the next restart.
- **Mode 0:** Armed = 0, RcvTimeout = 0, RTO_Pls = 0; counters held cleared.
- **Mode 1 (one-shot):**
  - WE_RHR arms and restarts.
  - RE_RHR disarms and clears RcvTimeout.
  - Expiry sets RcvTimeout, pulses RTO_Pls and disarms.
- **Mode 2 (FIFO):**
  - Armed while FIFO_Empty = 0.
  - WE_RHR or RE_RHR restarts the timer.
  - Expiry sets RcvTimeout and stops counting (Armed = 0) until the next WE_RHR/RE_RHR.
  - RcvTimeout is cleared by RE_RHR or by FIFO_Empty = 1.
- **Mode 3 (idle-line):**
  - WE_RHR arms, restarts and clears RcvTimeout.
  - RxBusy = 1 holds the counters cleared while remaining armed.
  - Expiry sets RcvTimeout and disarms.
  - RE_RHR clears RcvTimeout only.
- **Mode change:** any change of Mode (registered copy compared) clears RcvTimeout, Armed and the counters on the following cycle.
- **Priority, highest first:**
  1. Rst_n = 0
  2. Mode change
  3. Clear (RE_RHR / FIFO_Empty as applicable)
  4. Restart (WE_RHR)
  5. Expiry
- **Simultaneous events:**
  - WE_RHR in the same cycle as the expiry CE: restart, no flag, no strobe.
  - RE_RHR in the same cycle as expiry in modes 1/2: flag remains 0, no strobe.
- **Counter terminal counts** are registered (pipelined) so that no count compare sits in the expiry path; the pipelining must still produce exact T.

## Timing
- **Reset values:** RcvTimeout = 0, RTO_Pls = 0, Armed = 0, all counters and shadows = 0.
- **Arm latency:** Armed rises on the Clk edge sampling WE_RHR (mode 1/3) or FIFO_Empty = 0 (mode 2).
- **Count start:** the first counted CE_OvrSmp is the first CE pulse after the arming edge; a CE coincident with WE_RHR is not counted.
- **Expiry:**
  - RcvTimeout and RTO_Pls assert on the Clk edge that samples the T-th counted CE pulse.
  - RTO_Pls deasserts on the next edge.
- **Min/max:**
  - CCntVal = 0, RTOVal = 0 gives T = pOvrSmp.
  - All-ones gives T = 2^pCCntW·2^pRTOW·pOvrSmp with no counter wrap before expiry.
- **CE_OvrSmp:** may be continuously high (T in Clk cycles) or sparse; behaviour is identical in CE counts.

## Test plan
- **Mode 1, basic expiry:** pOvrSmp = 16, CCntVal = 9, RTOVal = 3, CE every cycle, single WE_RHR → RcvTimeout and RTO_Pls assert exactly 640 cycles later; RE_RHR clears RcvTimeout the next cycle.
- **Mode 1, simultaneous events:** WE_RHR at CE pulse 639 restarts (no flag, expiry 640 cycles after that WE_RHR); RE_RHR coincident with the 640th CE → RcvTimeout stays 0, RTO_Pls stays 0.
- **Mode 2 (FIFO):** two WE_RHR 100 cycles apart restart the timer, so expiry lands 640 after the second; after expiry no re-pulse while idle; FIFO_Empty rising clears RcvTimeout; RE_RHR with FIFO non-empty restarts the timer.
- **Mode 3 (idle-line):** RxBusy held for 300 cycles starting 500 cycles after WE_RHR → no expiry, count resumes from 0 after RxBusy falls (expiry 640 CE later); RE_RHR clears flag without disarming.
- **Boundaries:**
  - CCntVal = 0, RTOVal = 0 with CE every 4th cycle → expiry after 16 CE pulses (64 cycles).
  - CCntVal = RTOVal = 15 → 4096 CE.
  - CCntVal changed mid-count is ignored.
- **Reset and mode change:** Rst_n low mid-count → outputs 0 next edge, no expiry afterwards without new WE_RHR; Mode 1→0→1 with flag set → flag cleared one cycle after change.
